dnn_batch_sequencer: RTL and testbench

- Synthesizable batch driver and self-checker for the dnn classifier core.
- Streams NUM_SAMPLES feature vectors from a synchronous sample memory onto the dnn x_data/x_valid stream and waits for each class_id/class_valid result.
- Compares each result against the truth label stored after each vector and accumulates correct/total counts.
- Replaces single-vector, testbench-only checking with a reusable on-chip accuracy harness.

---
 rtl/dnn_batch_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_dnn_batch_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_batch_sequencer.sv
// -----------------------------------------------------------------------------
// dnn_batch_sequencer
//
// Batch driver and accuracy checker for the dnn classifier core. It reads
// NUM_SAMPLES feature vectors from a synchronous sample memory, streams each
// one to the dnn, waits for the class result and compares it with the truth
// label stored directly after the vector.
//
// Optional feature: define DNN_SEQ_TIMEOUT_EN to enable a result watchdog.
// Without it the sequencer waits indefinitely and timeout_err is tied to 0.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         single-cycle pulse that begins a batch (ignored while busy)
//   busy          high from the cycle after start is accepted until done
//   done          one-cycle pulse when the batch completes
//   mem_addr      sample memory read address (linear from 0)
//   mem_rd_en     sample memory read strobe
//   mem_rdata     read data, valid exactly one cycle after mem_rd_en
//   x_data        feature word to the dnn (0 whenever x_valid is low)
//   x_valid       feature qualifier to the dnn
//   class_id      dnn result
//   class_valid   dnn result qualifier
//   correct_cnt   samples classified correctly
//   sample_cnt    samples completed
//   proto_err     sticky: class_valid seen outside WAIT_RES
//   timeout_err   sticky: watchdog expired (optional feature)
//   state_dbg     current FSM state, for debug and checkers
//
// Handshake: the feature stream has no back-pressure. A word is transferred
// on every cycle x_valid is high; a result is transferred on every cycle
// class_valid is high. Neither side can stall the other.
//
// Memory layout: sample s occupies words s*(NUM_FEATURES+1) onward, first
// NUM_FEATURES feature words and then one label word.
// -----------------------------------------------------------------------------
module dnn_batch_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_FEATURES   = 784,
  parameter int NUM_SAMPLES    = 16,
  parameter int NUM_CLASSES    = 10,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int AW = $clog2(NUM_SAMPLES * (NUM_FEATURES + 1)),
  localparam int CW = $clog2(NUM_CLASSES),
  localparam int SW = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] x_data,
  output logic                  x_valid,
  input  logic [CW-1:0]         class_id,
  input  logic                  class_valid,
  output logic [SW-1:0]         correct_cnt,
  output logic [SW-1:0]         sample_cnt,
  output logic                  proto_err,
  output logic                  timeout_err,
  output logic [2:0]            state_dbg
);

  localparam int FW = $clog2(NUM_FEATURES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [FW-1:0] FEAT_LAST = FW'(NUM_FEATURES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SW-1:0] SAMP_LAST = SW'(NUM_SAMPLES - 1);

  // LATCH is the cycle the label word arrives from memory.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_LABEL  = 3'd2,
    S_LATCH  = 3'd3,
    S_WAIT   = 3'd4,
    S_GAP    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic [FW-1:0]   feat_cnt_q;
  logic [GW-1:0]   gap_cnt_q;
  logic [CW-1:0]   label_q;
  logic            label_bad_q;
  logic            x_valid_q;
  logic [SW-1:0]   correct_cnt_q;
  logic [SW-1:0]   sample_cnt_q;
  logic            proto_err_q;
  logic            result_ev;
  logic            timeout_ev;

`ifdef DNN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]   wd_q;
  logic            timeout_err_q;
`endif

  // Next-state and combinational outputs.
  always_comb begin
    state_d    = state_q;
    mem_rd_en  = 1'b0;
    result_ev  = 1'b0;
    timeout_ev = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_STREAM;
      end
      S_STREAM: begin
        mem_rd_en = 1'b1;
        if (feat_cnt_q == FEAT_LAST) state_d = S_LABEL;
      end
      S_LABEL: begin
        mem_rd_en = 1'b1;
        state_d   = S_LATCH;
      end
      S_LATCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A real result on the expiry cycle wins over the watchdog.
        if (class_valid) begin
          result_ev = 1'b1;
        end
`ifdef DNN_SEQ_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          result_ev  = 1'b1;
          timeout_ev = 1'b1;
        end
`endif
        if (result_ev) begin
          if (sample_cnt_q == SAMP_LAST) state_d = S_DONE;
          else if (GAP_CYCLES > 0)       state_d = S_GAP;
          else                           state_d = S_STREAM;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_STREAM;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      feat_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      label_q       <= '0;
      label_bad_q   <= 1'b0;
      x_valid_q     <= 1'b0;
      correct_cnt_q <= '0;
      sample_cnt_q  <= '0;
      proto_err_q   <= 1'b0;
`ifdef DNN_SEQ_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;

      // Feature reads become x_valid one cycle later, when the data returns.
      // The label read is not forwarded.
      x_valid_q <= (state_q == S_STREAM);

      if (mem_rd_en) addr_q <= addr_q + 1'b1;

      feat_cnt_q <= (state_q == S_STREAM && feat_cnt_q != FEAT_LAST) ?
                    feat_cnt_q + 1'b1 : '0;
      gap_cnt_q  <= (state_q == S_GAP && gap_cnt_q != GAP_LAST) ?
                    gap_cnt_q + 1'b1 : '0;
`ifdef DNN_SEQ_TIMEOUT_EN
      wd_q <= (state_q == S_WAIT && !result_ev) ? wd_q + 1'b1 : '0;
      if (timeout_ev) timeout_err_q <= 1'b1;
`endif

      if (state_q == S_LATCH) begin
        label_q     <= mem_rdata[CW-1:0];
        label_bad_q <= (mem_rdata >= DATA_WIDTH'(NUM_CLASSES));
      end

      if (result_ev) begin
        sample_cnt_q <= sample_cnt_q + 1'b1;
        if (!timeout_ev && !label_bad_q && class_id == label_q)
          correct_cnt_q <= correct_cnt_q + 1'b1;
      end

      // Batch start: clear results; later assignments below still win.
      if (state_q == S_IDLE && start) begin
        addr_q        <= '0;
        correct_cnt_q <= '0;
        sample_cnt_q  <= '0;
        proto_err_q   <= 1'b0;
`ifdef DNN_SEQ_TIMEOUT_EN
        timeout_err_q <= 1'b0;
`endif
      end

      if (class_valid && state_q != S_WAIT) proto_err_q <= 1'b1;
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign mem_addr    = addr_q;
  assign x_valid     = x_valid_q;
  assign x_data      = x_valid_q ? mem_rdata : '0;
  assign correct_cnt = correct_cnt_q;
  assign sample_cnt  = sample_cnt_q;
  assign proto_err   = proto_err_q;
  assign state_dbg   = state_q;
`ifdef DNN_SEQ_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dnn_batch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dnn_batch_sequencer
//
// Bench for dnn_batch_sequencer with a small configuration (4 features,
// 3 samples, 10 classes, gap 2, watchdog 8). A table of batch records holds
// labels, dnn responses and expected final counts. Feature words are pushed
// to exp_q when loaded into the memory model and popped as x_valid beats
// appear. Hand-written sequences cover reset state and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_dnn_batch_sequencer;

  localparam int DW  = 16;
  localparam int NF  = 4;
  localparam int NS  = 3;
  localparam int NC  = 10;
  localparam int GAP = 2;
  localparam int TO  = 8;
  localparam int AW  = $clog2(NS * (NF + 1));
  localparam int CW  = $clog2(NC);
  localparam int SW  = $clog2(NS + 1);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          class_valid = 1'b0;
  logic [CW-1:0] class_id = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, done, mem_rd_en, x_valid, proto_err, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] x_data;
  logic [SW-1:0] correct_cnt, sample_cnt;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  dnn_batch_sequencer #(
    .DATA_WIDTH(DW), .NUM_FEATURES(NF), .NUM_SAMPLES(NS),
    .NUM_CLASSES(NC), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .x_data(x_data), .x_valid(x_valid), .class_id(class_id),
    .class_valid(class_valid), .correct_cnt(correct_cnt),
    .sample_cnt(sample_cnt), .proto_err(proto_err),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // Synchronous sample memory: data one cycle after the read strobe.
  logic [DW-1:0] mem [0:NS*(NF+1)-1];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (x_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL x_extra actual=%0d required=none at %0t", x_data, $time);
        end else begin
          check("x_data", x_data, exp_q.pop_front());
        end
      end else begin
        check("x_data_idle", x_data, 0);
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    int                  base;     // 0: random feature words
    logic [2:0][DW-1:0]  lbl;
    logic [2:0][CW-1:0]  resp;
    logic [2:0]          silent;   // dnn never answers this sample
    bit                  inject;   // start + class_valid during first stream
    int                  exp_correct;
    int                  exp_proto;
    int                  exp_timeout;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int base,
                         input logic [DW-1:0] l0, l1, l2,
                         input logic [CW-1:0] r0, r1, r2,
                         input logic [2:0] silent, input bit inject,
                         input int ec, ep, et);
    vec_t v;
    v.base = base;
    v.lbl[0] = l0;  v.lbl[1] = l1;  v.lbl[2] = l2;
    v.resp[0] = r0; v.resp[1] = r1; v.resp[2] = r2;
    v.silent = silent;
    v.inject = inject;
    v.exp_correct = ec;
    v.exp_proto   = ep;
    v.exp_timeout = et;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_batch(input int vi);
    vec_t v;
    int n;
    int d0;
    logic [DW-1:0] w;
    v = vecs[vi];
    for (int s = 0; s < NS; s++) begin
      for (int f = 0; f < NF; f++) begin
        w = (v.base != 0) ? DW'(v.base + s * NF + f) : DW'($urandom_range(0, 65535));
        mem[s*(NF+1)+f] = w;
        exp_q.push_back(w);
      end
      mem[s*(NF+1)+NF] = v.lbl[s];
    end
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);

    for (int s = 0; s < NS; s++) begin
      n = 0;
      while (!x_valid && n < 50) begin tick(); n++; end
      if (!x_valid) begin
        check("x_valid_wait", x_valid, 1);
        return;
      end
      n = 0;
      while (x_valid && n < NF + 4) begin
        if (v.inject && s == 0 && n == 1) begin
          start = 1'b1;
          class_valid = 1'b1;
          class_id = 4'd3;
        end
        tick();
        start = 1'b0;
        class_valid = 1'b0;
        n++;
      end
      check("x_run_len", n, NF);

      if (v.silent[s]) begin
        n = 0;
        while (sample_cnt != SW'(s + 1) && n < TO + 20) begin tick(); n++; end
        check("timeout_latency", n, TO + 1);
        check("timeout_err", timeout_err, 1);
      end else begin
        tick();
        tick();
        class_valid = 1'b1;
        class_id = v.resp[s];
        tick();
        class_valid = 1'b0;
      end
      check("sample_cnt_step", sample_cnt, s + 1);

      // Result recorded this cycle; GAP idle cycles, then the first feature.
      if (s < NS - 1) begin
        n = 0;
        while (!x_valid && n < 50) begin tick(); n++; end
        check("gap_latency", n, GAP + 1);
      end
    end

    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    tick();
    check("done_low_after", done, 0);
    check("busy_idle", busy, 0);
    check("correct_cnt", correct_cnt, v.exp_correct);
    check("sample_cnt", sample_cnt, NS);
    check("proto_err", proto_err, v.exp_proto);
    check("timeout_err_end", timeout_err, v.exp_timeout);
    check("done_count", done_cnt - d0, 1);
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    int n;

    //       base lbl0     lbl1   lbl2    r0 r1 r2  silent  inj  ec ep et
    add_vec(1, 16'd7,    16'd7, 16'd7,  7, 7, 7, 3'b000, 0, 3, 0, 0);
    add_vec(0, 16'd7,    16'd3, 16'd9,  7, 5, 9, 3'b000, 0, 2, 0, 0);
    add_vec(0, 16'd12,   16'd4, 16'd2, 12, 4, 0, 3'b000, 0, 1, 0, 0);
    add_vec(0, 16'd0,    16'd9, 16'd10, 0, 9, 10, 3'b000, 0, 2, 0, 0);
    add_vec(0, 16'h0017, 16'd5, 16'd1,  7, 5, 1, 3'b000, 0, 2, 0, 0);
    add_vec(0, 16'd1,    16'd2, 16'd3,  1, 2, 3, 3'b000, 1, 3, 1, 0);
    add_vec(0, 16'd4,    16'd4, 16'd4,  4, 0, 4, 3'b000, 0, 2, 0, 0);
`ifdef DNN_SEQ_TIMEOUT_EN
    add_vec(0, 16'd7,    16'd3, 16'd9,  7, 3, 9, 3'b010, 0, 2, 0, 1);
`endif

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x_valid", x_valid, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_correct", correct_cnt, 0);
    check("rst_sample", sample_cnt, 0);
    check("rst_proto", proto_err, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    for (int i = 0; i < vecs.size(); i++) run_batch(i);

    // Reset in the middle of a stream
    for (int a = 0; a < NS * (NF + 1); a++) mem[a] = DW'($urandom_range(0, 65535));
    for (int s = 0; s < NS; s++)
      for (int f = 0; f < NF; f++) exp_q.push_back(mem[s*(NF+1)+f]);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!x_valid && n < 50) begin tick(); n++; end
    check("mid_x_valid", x_valid, 1);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("mid_rst_x_valid", x_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_addr", mem_addr, 0);
    repeat (10) tick();
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_still_idle", busy, 0);

    // Recovery: a full batch after the abort
    run_batch(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
